dc_write_ctrl: RTL and testbench

- Write-side controller of the dual-clock slice; sits directly upstream of the shared data buffer in the write clock domain.
- Accepts words over a valid/ready handshake and drives the buffer's one-hot write pointer and write data.
- Synchronizes the reader's one-hot read pointer into the write domain and withholds ready when the buffer is full.
- Usable capacity is BUFFER_DEPTH-1 words; one slot always stays empty, so full and empty are unambiguous.

---
 rtl/dc_write_ctrl.sv | 92 +++++++++
 tb/tb_dc_write_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dc_write_ctrl.sv
// dc_write_ctrl: write-domain side of the dual-clock buffer slice.
// Accepts producer words, steers them into the shared buffer through a
// one-hot write pointer, and uses a synchronized copy of the reader's
// one-hot read pointer to withhold ready_out while the buffer is full.
// One slot always stays empty, so usable capacity is BUFFER_DEPTH-1 words.
// Legal ranges: BUFFER_DEPTH 4..1024, SYNC_STAGES 2..3.
//
// Handshake: a word moves when valid_in && ready_out at the rising edge
// of clk. ready_out is built only from registers and rstn, never from
// valid_in. The producer keeps data_in stable while valid_in is high and
// ready_out is low.
module dc_write_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [BUFFER_DEPTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]   write_data,
    input  logic [BUFFER_DEPTH-1:0] read_pointer,
    output logic                    full
);

    // Both sides come out of reset pointing at slot 0.
    localparam logic [BUFFER_DEPTH-1:0] PTR_RESET = BUFFER_DEPTH'(1);

    logic [BUFFER_DEPTH-1:0]                  wp_q;
    logic [BUFFER_DEPTH-1:0]                  wp_d;
    logic [BUFFER_DEPTH-1:0]                  wp_nxt;
    logic [SYNC_STAGES-1:0][BUFFER_DEPTH-1:0] sync_q;
    logic [BUFFER_DEPTH-1:0]                  rp_prev_q;
    logic [BUFFER_DEPTH-1:0]                  rp_seen;
    logic                                     full_c;
    logic                                     transfer;

    // Slot the pointer moves to on the next accepted word (rotate left).
    assign wp_nxt = {wp_q[BUFFER_DEPTH-2:0], wp_q[BUFFER_DEPTH-1]};

    // A one-hot pointer move flips two bits, so the last sync stage may
    // briefly show zero or two bits set. OR-ing it with the previous sample
    // always covers the older read position, which can only make full
    // assert earlier, never later.
    assign rp_seen  = sync_q[SYNC_STAGES-1] | rp_prev_q;
    assign full_c   = |(wp_nxt & rp_seen);
    assign full     = full_c;
    assign ready_out = rstn & ~full_c;
    assign transfer = valid_in & ready_out;

    // The buffer writes the current slot on every edge; the free slot may
    // take idle garbage, which the reader cannot see yet.
    assign write_data    = data_in;
    assign write_pointer = wp_q;

    // Next write pointer: advance only on an accepted word.
    always_comb begin
        wp_d = wp_q;
        if (transfer) begin
            wp_d = wp_nxt;
        end
    end

    // Write pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q <= PTR_RESET;
        end else begin
            wp_q <= wp_d;
        end
    end

    // Read-pointer synchronizer chain plus hold register for the last stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= {SYNC_STAGES{PTR_RESET}};
            rp_prev_q <= PTR_RESET;
        end else begin
            sync_q[0] <= read_pointer;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            rp_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // The write pointer must always select exactly one slot.
    a_wp_onehot : assert property (@(posedge clk) disable iff (!rstn) $onehot(wp_q));

endmodule

// File: tb/tb_dc_write_ctrl.sv
// tb_dc_write_ctrl: directed bench for dc_write_ctrl (DATA_WIDTH 32,
// BUFFER_DEPTH 8, SYNC_STAGES 2). Models the shared buffer and the reader,
// keeps an expected-word queue, and checks pointers, status and data order.
module tb_dc_write_ctrl;

    localparam int DW = 32;
    localparam int BD = 8;

    // Clock and reset
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [BD-1:0] write_pointer;
    logic [DW-1:0] write_data;
    logic [BD-1:0] read_pointer;
    logic          full;

    dc_write_ctrl #(
        .DATA_WIDTH  (DW),
        .BUFFER_DEPTH(BD),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .write_pointer(write_pointer),
        .write_data   (write_data),
        .read_pointer (read_pointer),
        .full         (full)
    );

    // Scoreboard state and buffer/reader model
    int            n_cmp = 0;
    int            n_err = 0;
    int            sent  = 0;
    logic          accepted = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[BD];
    logic [BD-1:0] exp_wp;
    logic [BD-1:0] rp;

    localparam logic [DW-1:0] FILL_BASE = 32'hA5A5_0000;
    localparam logic [DW-1:0] WRAP_BASE = 32'hB000_0000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BD-1:0] rotl(input logic [BD-1:0] p);
        return {p[BD-2:0], p[BD-1]};
    endfunction

    function automatic int slot_of(input logic [BD-1:0] p);
        int idx = 0;
        for (int i = BD - 1; i >= 0; i--) begin
            if (p[i]) idx = i;
        end
        return idx;
    endfunction

    // Driver: record what the coming edge does, then step one cycle.
    task automatic clock_edge();
        accepted = valid_in && ready_out;
        if (accepted) begin
            check("no_overflow", 64'(exp_q.size() < BD - 1), 64'd1);
            exp_q.push_back(data_in);
            exp_wp = rotl(exp_wp);
            sent++;
        end
        mem[slot_of(write_pointer)] = write_data;
        @(posedge clk);
        #1;
    endtask

    // Reader model: consume the oldest word and advance the read pointer.
    task automatic read_one();
        check("read_data", 64'(mem[slot_of(rp)]), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        rp = rotl(rp);
        read_pointer = rp;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1a: reset from time zero with valid_in high
        valid_in     = 1'b1;
        data_in      = 32'h0000_1234;
        read_pointer = 8'h01;
        rp           = 8'h01;
        exp_wp       = 8'h01;
        #1 rstn = 1'b0;
        #1;
        check("reset_wp", 64'(write_pointer), 64'h01);
        check("reset_ready", 64'(ready_out), 64'd0);
        check("reset_full", 64'(full), 64'd0);
        @(posedge clk);
        #1;
        check("reset_hold_wp", 64'(write_pointer), 64'h01);
        check("reset_hold_ready", 64'(ready_out), 64'd0);
        valid_in = 1'b0;
        rstn     = 1'b1;
        #1;
        check("release_ready", 64'(ready_out), 64'd1);

        // Test 2: fill with the reader frozen at slot 0
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            data_in  = FILL_BASE + DW'(sent);
            #1;
            check("fill_ready", 64'(ready_out), 64'(i < 7));
            check("fill_full", 64'(full), 64'(i >= 7));
            check("fill_wp", 64'(write_pointer), 64'(exp_wp));
            check("fill_wdata", 64'(write_data), 64'(FILL_BASE + DW'(sent)));
            clock_edge();
        end
        check("fill_count", 64'(sent), 64'd7);
        check("fill_wp_end", 64'(write_pointer), 64'h80);
        check("fill_full_end", 64'(full), 64'd1);
        check("fill_ready_end", 64'(ready_out), 64'd0);

        // Test 3: reader frees one slot; ready rises after three edges
        read_one();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("release_wait", 64'(ready_out), 64'd0);
            clock_edge();
        end
        check("release_rise", 64'(ready_out), 64'd1);
        clock_edge();
        check("release_wrap_wp", 64'(write_pointer), 64'h01);
        check("release_refull", 64'(ready_out), 64'd0);

        // Test 5: glitchy read pointer while full never opens ready
        data_in = FILL_BASE + DW'(sent);
        read_pointer = 8'h00;
        #1;
        check("glitch_zero", 64'(ready_out), 64'd0);
        clock_edge();
        read_pointer = 8'h03;
        #1;
        check("glitch_two", 64'(ready_out), 64'd0);
        clock_edge();
        read_pointer = rp;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("glitch_settle", 64'(ready_out), 64'd0);
            clock_edge();
        end

        // Drain the buffer so the wrap run starts empty
        valid_in = 1'b0;
        for (int k = 0; k < 7; k++) begin
            read_one();
            clock_edge();
        end
        for (int k = 0; k < 4; k++) clock_edge();
        check("drained_ready", 64'(ready_out), 64'd1);
        check("drained_full", 64'(full), 64'd0);

        // Test 4: reader tracks the writer; 20 transfers without a stall
        valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() > 0) read_one();
            data_in = WRAP_BASE + DW'(sent);
            #1;
            check("wrap_no_stall", 64'(ready_out), 64'd1);
            check("wrap_wp", 64'(write_pointer), 64'(exp_wp));
            if (i == 7) check("wrap_at_80", 64'(write_pointer), 64'h80);
            if (i == 8) check("wrap_to_01", 64'(write_pointer), 64'h01);
            clock_edge();
        end

        // Test 6: random valid against a random reader
        accepted = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) read_one();
            if (!(valid_in && !accepted)) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = $urandom();
            end
            #1;
            check("rand_onehot", 64'($onehot(write_pointer)), 64'd1);
            check("rand_wp", 64'(write_pointer), 64'(exp_wp));
            clock_edge();
        end
        while (exp_q.size() > 0) read_one();

        // Test 1b: reset mid-stream with valid_in high
        valid_in = 1'b1;
        data_in  = 32'hDEAD_BEEF;
        #1 rstn = 1'b0;
        #1;
        check("midreset_wp", 64'(write_pointer), 64'h01);
        check("midreset_ready", 64'(ready_out), 64'd0);
        check("midreset_full", 64'(full), 64'd0);
        @(posedge clk);
        #1;
        check("midreset_hold_wp", 64'(write_pointer), 64'h01);
        check("midreset_hold_ready", 64'(ready_out), 64'd0);
        read_pointer = 8'h01;
        rp           = 8'h01;
        exp_wp       = 8'h01;
        valid_in     = 1'b0;
        rstn         = 1'b1;
        #1;
        check("post_reset_ready", 64'(ready_out), 64'd1);
        valid_in = 1'b1;
        data_in  = 32'h0BAD_F00D;
        #1;
        clock_edge();
        check("post_reset_xfer_wp", 64'(write_pointer), 64'h02);
        valid_in = 1'b0;
        read_one();
        clock_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
